// File: rtl/load_store_initiator_pkg.sv
// Shared definitions for the data-memory load/store initiator: size codes,
// FSM state constants, the captured request record and alignment helpers.
package load_store_initiator_pkg;

  localparam int unsigned ADDR_W_DEF = 10;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  typedef logic [2:0] ls_state_t;

  localparam ls_state_t ST_IDLE  = 3'd0;
  localparam ls_state_t ST_RD    = 3'd1;
  localparam ls_state_t ST_MERGE = 3'd2;
  localparam ls_state_t ST_WR    = 3'd3;
  localparam ls_state_t ST_DONE  = 3'd4;

  typedef struct packed {
    logic        write;
    logic [1:0]  size;
    logic        uns;
    logic [1:0]  offset;
    logic [31:0] wdata;
  } ls_req_t;

  // Size code 3 behaves exactly like a word access.
  function automatic logic is_word(input logic [1:0] size);
    return size >= SZ_WORD;
  endfunction

  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] offset);
    if (is_word(size)) return offset != 2'b00;
    if (size == SZ_HALF) return offset[0];
    return 1'b0;
  endfunction

endpackage

// File: rtl/load_store_initiator_if.sv
// Signal bundle between the MEM stage, the load/store initiator and data memory.
interface load_store_initiator_if
  import load_store_initiator_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF
) ();

  // Handshakes: ls_valid is sampled only while ls_busy=0 and ls_done pulses
  // once per accepted request; mem_req is held until the cycle after the edge
  // that samples the single-cycle mem_ack, and acks outside a request are ignored.
  logic              ls_valid;
  logic              ls_write;
  logic [1:0]        ls_size;
  logic              ls_unsigned;
  logic [31:0]       ls_addr;
  logic [31:0]       ls_wdata;
  logic [31:0]       ls_rdata;
  logic              ls_done;
  logic              ls_misaligned;
  logic              ls_error;
  logic              ls_busy;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;
  logic              mem_ack;

  modport master (
    input  ls_valid, ls_write, ls_size, ls_unsigned, ls_addr, ls_wdata,
    input  mem_rdata, mem_ack,
    output ls_rdata, ls_done, ls_misaligned, ls_error, ls_busy,
    output mem_req, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    output ls_valid, ls_write, ls_size, ls_unsigned, ls_addr, ls_wdata,
    output mem_rdata, mem_ack,
    input  ls_rdata, ls_done, ls_misaligned, ls_error, ls_busy,
    input  mem_req, mem_we, mem_addr, mem_wdata
  );

endinterface

// File: rtl/ls_lane_align.sv
// Byte-lane steering: extracts/extends load data from a memory word and merges
// sub-word store data into a previously read word (little-endian lanes).
module ls_lane_align
  import load_store_initiator_pkg::*;
(
  input  logic [1:0]  size,
  input  logic        uns,
  input  logic [1:0]  offset,
  input  logic [31:0] rd_word,
  output logic [31:0] load_data,
  input  logic [31:0] old_word,
  input  logic [31:0] st_data,
  output logic [31:0] merged_word
);

  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  always_comb begin
    lane_b = rd_word[7:0];
    case (offset)
      2'd1:    lane_b = rd_word[15:8];
      2'd2:    lane_b = rd_word[23:16];
      2'd3:    lane_b = rd_word[31:24];
      default: lane_b = rd_word[7:0];
    endcase
    lane_h = offset[1] ? rd_word[31:16] : rd_word[15:0];

    case (size)
      SZ_BYTE: load_data = {{24{lane_b[7] & ~uns}}, lane_b};
      SZ_HALF: load_data = {{16{lane_h[15] & ~uns}}, lane_h};
      default: load_data = rd_word;
    endcase

    merged_word = old_word;
    if (size == SZ_BYTE) begin
      case (offset)
        2'd1:    merged_word[15:8]  = st_data[7:0];
        2'd2:    merged_word[23:16] = st_data[7:0];
        2'd3:    merged_word[31:24] = st_data[7:0];
        default: merged_word[7:0]   = st_data[7:0];
      endcase
    end else if (size == SZ_HALF) begin
      if (offset[1]) merged_word[31:16] = st_data[15:0];
      else           merged_word[15:0]  = st_data[15:0];
    end else begin
      merged_word = st_data;
    end
  end

endmodule

// File: rtl/load_store_initiator.sv
// MEM-stage load/store initiator: one access at a time over a req/ack word
// memory, read-modify-write for sub-word stores, misalign and timeout reporting.
module load_store_initiator
  import load_store_initiator_pkg::*;
#(
  parameter int unsigned ADDR_W  = ADDR_W_DEF,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic                  clk,
  input  logic                  reset,
  load_store_initiator_if.master bus,
  output logic [2:0]            state_dbg
);

  localparam int unsigned      CNT_W    = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  ls_state_t         state_q, state_d;
  ls_req_t           req_q, req_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [31:0]       word_q, word_d;
  logic [31:0]       rdata_q, rdata_d;
  logic [31:0]       mem_wdata_q, mem_wdata_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic              done_q, done_d;
  logic              mis_q, mis_d;
  logic              err_q, err_d;
  logic [31:0]       load_data;
  logic [31:0]       merged_word;
  logic              unused_addr_hi;

  assign unused_addr_hi = ^bus.ls_addr[31:ADDR_W+2];

  ls_lane_align u_align (
    .size        (req_q.size),
    .uns         (req_q.uns),
    .offset      (req_q.offset),
    .rd_word     (bus.mem_rdata),
    .load_data   (load_data),
    .old_word    (word_q),
    .st_data     (req_q.wdata),
    .merged_word (merged_word)
  );

  always_comb begin
    state_d     = state_q;
    req_d       = req_q;
    cnt_d       = cnt_q;
    word_d      = word_q;
    rdata_d     = rdata_q;
    mem_wdata_d = mem_wdata_q;
    mem_addr_d  = mem_addr_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    done_d      = 1'b0;
    mis_d       = 1'b0;
    err_d       = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.ls_valid) begin
          req_d.write  = bus.ls_write;
          req_d.size   = bus.ls_size;
          req_d.uns    = bus.ls_unsigned;
          req_d.offset = bus.ls_addr[1:0];
          req_d.wdata  = bus.ls_wdata;
          mem_addr_d   = bus.ls_addr[ADDR_W+1:2];
          cnt_d        = '0;
          if (is_misaligned(bus.ls_size, bus.ls_addr[1:0])) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
            mis_d   = 1'b1;
            rdata_d = '0;
          end else if (bus.ls_write && is_word(bus.ls_size)) begin
            state_d     = ST_WR;
            mem_req_d   = 1'b1;
            mem_we_d    = 1'b1;
            mem_wdata_d = bus.ls_wdata;
          end else begin
            state_d   = ST_RD;
            mem_req_d = 1'b1;
            mem_we_d  = 1'b0;
          end
        end
      end

      ST_RD, ST_WR: begin
        // An ack in the final allowed cycle still completes the access.
        if (bus.mem_ack) begin
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
          if (state_q == ST_RD) begin
            word_d = bus.mem_rdata;
            if (req_q.write) begin
              state_d = ST_MERGE;
            end else begin
              state_d = ST_DONE;
              done_d  = 1'b1;
              rdata_d = load_data;
            end
          end else begin
            state_d = ST_DONE;
            done_d  = 1'b1;
            rdata_d = '0;
          end
        end else if (cnt_q == CNT_LAST) begin
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
          state_d   = ST_DONE;
          done_d    = 1'b1;
          err_d     = 1'b1;
          rdata_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      ST_MERGE: begin
        state_d     = ST_WR;
        mem_req_d   = 1'b1;
        mem_we_d    = 1'b1;
        mem_wdata_d = merged_word;
        cnt_d       = '0;
      end

      ST_DONE: state_d = ST_IDLE;

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      req_q       <= '0;
      cnt_q       <= '0;
      word_q      <= '0;
      rdata_q     <= '0;
      mem_wdata_q <= '0;
      mem_addr_q  <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      done_q      <= 1'b0;
      mis_q       <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      req_q       <= req_d;
      cnt_q       <= cnt_d;
      word_q      <= word_d;
      rdata_q     <= rdata_d;
      mem_wdata_q <= mem_wdata_d;
      mem_addr_q  <= mem_addr_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      done_q      <= done_d;
      mis_q       <= mis_d;
      err_q       <= err_d;
    end
  end

  assign bus.ls_rdata      = rdata_q;
  assign bus.ls_done       = done_q;
  assign bus.ls_misaligned = mis_q;
  assign bus.ls_error      = err_q;
  assign bus.ls_busy       = (state_q != ST_IDLE);
  assign bus.mem_req       = mem_req_q;
  assign bus.mem_we        = mem_we_q;
  assign bus.mem_addr      = mem_addr_q;
  assign bus.mem_wdata     = mem_wdata_q;
  assign state_dbg         = state_q;

endmodule

// File: doc/load_store_initiator.md
Name: load_store_initiator

Overview:
- Initiator side of the data-memory request/acknowledge protocol. It sits between the MIPS MEM stage and a multi-cycle word-addressed data memory.
- Accepts one load or store at a time from the pipeline (lw/lh/lhu/lb/lbu/sw/sh/sb) and drives the memory request.
- Aligns and extends read data; performs read-modify-write for sub-word stores.
- Stalls the pipeline while busy; flags misaligned accesses and memory timeouts.

Parameters:
- ADDR_W, 10, word-address width driven to memory (1024 words).
- TIMEOUT, 15, max cycles mem_req may stay high without mem_ack before abort.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset.
- ls_valid  in  1  request from MEM stage; sampled only when ls_busy=0.
- ls_write  in  1  1=store, 0=load.
- ls_size  in  2  0=byte, 1=half, 2=word; 3 is treated as word.
- ls_unsigned  in  1  zero-extend loads (lbu/lhu); ignored for stores and words.
- ls_addr  in  32  byte address.
- ls_wdata  in  32  store data; low byte/half used for sb/sh.
- ls_rdata  out  32  load result; valid while ls_done=1.
- ls_done  out  1  one-cycle completion pulse.
- ls_misaligned  out  1  pulses with ls_done when the access was misaligned.
- ls_error  out  1  pulses with ls_done when a memory timeout occurred.
- ls_busy  out  1  high whenever state != IDLE; pipeline stall.
- mem_req  out  1  memory request; held until acknowledged.
- mem_we  out  1  1=write transaction.
- mem_addr  out  ADDR_W  word address = ls_addr[ADDR_W+1:2].
- mem_wdata  out  32  write data.
- mem_rdata  in  32  read data; valid in the cycle mem_ack=1.
- mem_ack  in  1  one-cycle acknowledge from memory.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE; all outputs 0; timeout counter 0.
- States: IDLE, RD, MERGE, WR, DONE.
- IDLE: on ls_valid, capture addr, wdata, size, unsigned, write into registers.
  - Misaligned (half with addr[0]=1, or word with addr[1:0]!=0): go to DONE with no memory transaction; ls_misaligned=1, ls_rdata=0.
  - Otherwise: load or sub-word store -> RD; word store -> WR.
- RD: mem_req=1, mem_we=0.
  - On mem_ack, latch mem_rdata.
  - Load -> DONE.
  - Sub-word store -> MERGE.
- MERGE: one cycle, mem_req=0.
  - Insert the byte/half from wdata into the latched word at lane addr[1:0]; lanes are little-endian (lane 0 = bits 7:0).
  - Go to WR.
- WR: mem_req=1, mem_we=1, mem_wdata = merged word (or ls_wdata for sw). On mem_ack -> DONE.
- DONE: ls_done=1 for exactly one cycle, then IDLE. ls_busy=1 in DONE, so a new request is accepted at the earliest in the cycle after the ls_done pulse.
- Load result rules:
  - byte: lane selected by addr[1:0], sign- or zero-extended to 32 bits.
  - half: lane selected by addr[1], sign- or zero-extended to 32 bits.
  - word: passed through unchanged.
  - ls_rdata holds its value until the next completion; it is 0 after stores.
- mem_req, mem_we, mem_addr and mem_wdata are registered. mem_req falls in the cycle after the edge that samples mem_ack.
- mem_ack received in IDLE, MERGE or DONE is ignored.
- Timeout:
  - Counter clears on entry to RD/WR and increments each cycle mem_req=1 without mem_ack.
  - At TIMEOUT: drop mem_req, go to DONE with ls_error=1, no write performed; a load returns ls_rdata=0.
  - If mem_ack arrives in the same cycle the count reaches TIMEOUT, the ack wins.
- Latency with zero-wait memory (ack in the first req cycle), counted from the accept edge to the ls_done cycle:
  - load / sw: ls_done high 2 cycles after accept.
  - sb/sh: ls_done high 4 cycles after accept.
- Reset asserted mid-transaction: immediate return to IDLE with all outputs 0. A pending write is dropped, never half-issued.

Decomposition:
- Shared package mem_pkg:
  - size encodings SZ_BYTE, SZ_HALF, SZ_WORD.
  - state enum.
  - default ADDR_W.
- Sub-module ls_lane_align (combinational):
  - load extract/extend: size, unsigned, offset, word -> result.
  - store merge: size, offset, old word, data -> merged word.
  - Instantiated once; the FSM stays in the top module.

Test Plan:
- Reset: hold reset=0 with mem_ack toggling -> all outputs 0, ls_busy=0; release -> still idle.
- lw, mem word 4 = 0x00000001, addr 0x10, zero-wait ack -> mem_addr=4, mem_we=0; ls_rdata=0x00000001 with ls_done 2 cycles after accept.
- lb/lbu, addr 0x13, word 4 = 0x80FF0011 -> lb gives 0xFFFFFF80, lbu gives 0x00000080.
- sb 0xAB to addr 0x21, word 8 = 0x11223344 -> read of word 8, then write of 0x1122AB44; ls_done 4 cycles after accept.
- lh to addr 0x05 -> no mem_req ever; ls_done=1 and ls_misaligned=1 next cycle; ls_rdata=0.
- Memory never acks a sw -> mem_req high 15 cycles, then low; ls_done=1, ls_error=1; ls_busy drops the cycle after.
